tt_mask_idx_agen: RTL and testbench

TT_MASK_IDX_AGEN -- requirements
Module: tt_mask_idx_agen

---
 rtl/tt_mask_idx_agen_pkg.sv | 18 +
 rtl/tt_credit_fifo.sv | 62 ++++++
 rtl/tt_mask_idx_agen.sv | 108 ++++++++++
 tb/tb_tt_mask_idx_agen.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mask_idx_agen_pkg.sv
// rtl/tt_mask_idx_agen_pkg.sv - shared mask/index item layout and credit defaults
package tt_mask_idx_agen_pkg;

  localparam int MI_IDX_W    = 64;
  localparam int MI_MASK_BIT = 64;
  localparam int MI_ITEM_W   = MI_IDX_W + 1;
  localparam int MI_CREDITS  = 2;

  // FIFO entry is {last, item}; item is {mask bit, index or mask word}
  typedef struct packed {
    logic                last;
    logic                mask;
    logic [MI_IDX_W-1:0] data;
  } mi_entry_t;

  localparam int MI_ENTRY_W = $bits(mi_entry_t);

endpackage

// File: rtl/tt_credit_fifo.sv
// rtl/tt_credit_fifo.sv - credit-sized FIFO; pushes while full are dropped
module tt_credit_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 66
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_empty,
  output logic             o_full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_ok;
  logic             pop_ok;

  assign o_empty = (count == '0);
  assign o_full  = (count == CNT_W'(DEPTH));
  assign push_ok = i_push & ~o_full;
  assign pop_ok  = i_pop & ~o_empty;
  assign o_rdata = mem[rd_ptr];

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop_ok) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tt_mask_idx_agen.sv
// rtl/tt_mask_idx_agen.sv - turns mask/index items into LSU element or word requests
module tt_mask_idx_agen
  import tt_mask_idx_agen_pkg::*;
#(
  parameter int DEPTH = MI_CREDITS,
  parameter int VLEN  = 256
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_memop_sync_start,
  input  logic                       i_memop_sync_end,
  input  logic                       i_is_indexed,
  input  logic [63:0]                i_base_addr,
  input  logic                       i_mask_idx_valid,
  input  logic [MI_ITEM_W-1:0]       i_mask_idx_item,
  input  logic                       i_mask_idx_last_idx,
  output logic                       o_mask_idx_credit,
  output logic                       o_req_valid,
  input  logic                       i_req_ready,
  output logic [63:0]                o_req_addr,
  output logic                       o_req_active,
  output logic [63:0]                o_req_mask_word,
  output logic [$clog2(VLEN+1)-1:0]  o_req_elem_idx,
  output logic                       o_req_last,
  output logic                       o_done,
  output logic                       o_err
);

  localparam int EW = $clog2(VLEN + 1);

  mi_entry_t             push_entry;
  mi_entry_t             head;
  logic [MI_ENTRY_W-1:0] head_bits;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  pop;

  logic [63:0]           base_q;
  logic                  indexed_q;
  logic [EW-1:0]         elem_idx_q;
  logic                  credit_q;
  logic                  done_q;
  logic                  err_q;
  logic [63:0]           elem_off;

  assign push_entry.last = i_mask_idx_last_idx;
  assign push_entry.mask = i_mask_idx_item[MI_MASK_BIT];
  assign push_entry.data = i_mask_idx_item[MI_IDX_W-1:0];

  tt_credit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (MI_ENTRY_W)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_push    (i_mask_idx_valid),
    .i_wdata   (push_entry),
    .i_pop     (pop),
    .o_rdata   (head_bits),
    .o_empty   (fifo_empty),
    .o_full    (fifo_full)
  );

  assign head = mi_entry_t'(head_bits);
  assign pop  = ~fifo_empty & i_req_ready;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      base_q     <= '0;
      indexed_q  <= 1'b0;
      elem_idx_q <= '0;
      credit_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      credit_q <= pop;
      done_q   <= pop & head.last;
      if (i_memop_sync_start) begin
        base_q    <= i_base_addr;
        indexed_q <= i_is_indexed;
      end else if (i_memop_sync_end) begin
        indexed_q <= 1'b0;
      end
      // start wins over a same-cycle pop; that pop still returns its credit above
      if (i_memop_sync_start) begin
        elem_idx_q <= '0;
      end else if (pop && (elem_idx_q != EW'(VLEN))) begin
        elem_idx_q <= elem_idx_q + 1'b1;
      end
      if ((i_mask_idx_valid & fifo_full) | (i_memop_sync_end & ~fifo_empty)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign elem_off = {{(64 - EW - 3){1'b0}}, elem_idx_q, 3'b000};

  assign o_req_valid       = ~fifo_empty;
  assign o_req_addr        = indexed_q ? (base_q + head.data) : (base_q + elem_off);
  assign o_req_active      = indexed_q ? head.mask : (|head.data);
  assign o_req_mask_word   = indexed_q ? 64'd0 : head.data;
  assign o_req_elem_idx    = elem_idx_q;
  assign o_req_last        = head.last;
  assign o_mask_idx_credit = credit_q;
  assign o_done            = done_q;
  assign o_err             = err_q;

endmodule

// File: tb/tb_tt_mask_idx_agen.sv
// tb/tb_tt_mask_idx_agen.sv - scoreboard bench for tt_mask_idx_agen
module tb_tt_mask_idx_agen;

  localparam int DEPTH = 2;
  localparam int VLEN  = 8;
  localparam int EW    = $clog2(VLEN + 1);

  logic          i_clk;
  logic          i_reset_n;
  logic          i_memop_sync_start;
  logic          i_memop_sync_end;
  logic          i_is_indexed;
  logic [63:0]   i_base_addr;
  logic          i_mask_idx_valid;
  logic [64:0]   i_mask_idx_item;
  logic          i_mask_idx_last_idx;
  logic          o_mask_idx_credit;
  logic          o_req_valid;
  logic          i_req_ready;
  logic [63:0]   o_req_addr;
  logic          o_req_active;
  logic [63:0]   o_req_mask_word;
  logic [EW-1:0] o_req_elem_idx;
  logic          o_req_last;
  logic          o_done;
  logic          o_err;

  tt_mask_idx_agen #(.DEPTH(DEPTH), .VLEN(VLEN)) dut (
    .i_clk               (i_clk),
    .i_reset_n           (i_reset_n),
    .i_memop_sync_start  (i_memop_sync_start),
    .i_memop_sync_end    (i_memop_sync_end),
    .i_is_indexed        (i_is_indexed),
    .i_base_addr         (i_base_addr),
    .i_mask_idx_valid    (i_mask_idx_valid),
    .i_mask_idx_item     (i_mask_idx_item),
    .i_mask_idx_last_idx (i_mask_idx_last_idx),
    .o_mask_idx_credit   (o_mask_idx_credit),
    .o_req_valid         (o_req_valid),
    .i_req_ready         (i_req_ready),
    .o_req_addr          (o_req_addr),
    .o_req_active        (o_req_active),
    .o_req_mask_word     (o_req_mask_word),
    .o_req_elem_idx      (o_req_elem_idx),
    .o_req_last          (o_req_last),
    .o_done              (o_done),
    .o_err               (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] addr;
    logic        active;
    logic [63:0] word;
    int          idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  bit          mdl_q[$];
  logic [63:0] m_base;
  bit          m_indexed;
  int          m_push_cnt;
  bit          exp_credit;
  bit          exp_done;
  bit          exp_err;
  bit          started;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // reference model: occupancy, drops, error and pulse expectations
  always @(negedge i_clk) begin
    bit          pop;
    bit          full;
    bit          acc;
    bit          idx_n;
    logic [63:0] base_n;
    int          eidx;
    exp_t        e;
    if (started) begin
      chk("req_valid", 64'(o_req_valid), 64'(mdl_q.size() > 0));
      chk("credit", 64'(o_mask_idx_credit), 64'(exp_credit));
      chk("done", 64'(o_done), 64'(exp_done));
      chk("err", 64'(o_err), 64'(exp_err));
    end
    started = 1'b1;
    if (!i_reset_n) begin
      mdl_q.delete();
      exp_q.delete();
      m_base = '0;
      m_indexed = 1'b0;
      m_push_cnt = 0;
      exp_credit = 1'b0;
      exp_done = 1'b0;
      exp_err = 1'b0;
    end else begin
      full = (mdl_q.size() == DEPTH);
      pop  = (mdl_q.size() > 0) && i_req_ready;
      acc  = i_mask_idx_valid && !full;
      if ((i_mask_idx_valid && full) || (i_memop_sync_end && mdl_q.size() > 0)) exp_err = 1'b1;
      exp_credit = pop;
      exp_done   = pop && mdl_q[0];
      if (pop) void'(mdl_q.pop_front());
      base_n = i_memop_sync_start ? i_base_addr : m_base;
      idx_n  = i_memop_sync_start ? i_is_indexed : (i_memop_sync_end ? 1'b0 : m_indexed);
      eidx   = i_memop_sync_start ? 0 : m_push_cnt;
      if (acc) begin
        e.idx  = eidx;
        e.last = i_mask_idx_last_idx;
        if (idx_n) begin
          e.addr   = base_n + i_mask_idx_item[63:0];
          e.active = i_mask_idx_item[64];
          e.word   = 64'd0;
        end else begin
          e.addr   = base_n + 64'(eidx) * 64'd8;
          e.active = (i_mask_idx_item[63:0] != 64'd0);
          e.word   = i_mask_idx_item[63:0];
        end
        exp_q.push_back(e);
        mdl_q.push_back(i_mask_idx_last_idx);
        eidx = (eidx < VLEN) ? eidx + 1 : VLEN;
      end
      m_push_cnt = eidx;
      m_base     = base_n;
      m_indexed  = idx_n;
    end
  end

  // monitor: every accepted request is checked against the scoreboard head
  always @(negedge i_clk) begin
    exp_t e;
    if (i_reset_n && o_req_valid === 1'b1 && i_req_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got unexpected request addr 0x%0h expected none at %0t", o_req_addr, $time);
      end else begin
        e = exp_q.pop_front();
        chk("req_addr", o_req_addr, e.addr);
        chk("req_active", 64'(o_req_active), 64'(e.active));
        chk("req_mask_word", o_req_mask_word, e.word);
        chk("req_elem_idx", 64'(o_req_elem_idx), 64'(e.idx));
        chk("req_last", 64'(o_req_last), 64'(e.last));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    i_memop_sync_start  = 1'b0;
    i_memop_sync_end    = 1'b0;
    i_mask_idx_valid    = 1'b0;
    i_mask_idx_last_idx = 1'b0;
  endtask

  task automatic start_memop(input bit idx, input logic [63:0] base);
    i_memop_sync_start = 1'b1;
    i_is_indexed = idx;
    i_base_addr = base;
    tick();
  endtask

  task automatic end_memop();
    i_memop_sync_end = 1'b1;
    tick();
  endtask

  task automatic push(input logic [64:0] item, input bit last);
    i_mask_idx_valid = 1'b1;
    i_mask_idx_item = item;
    i_mask_idx_last_idx = last;
    tick();
  endtask

  task automatic drain();
    int n = 0;
    i_req_ready = 1'b1;
    while (mdl_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    n_cmp++;
    if (mdl_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d entries left expected 0", mdl_q.size());
    end
    tick();
    tick();
  endtask

  function automatic logic [64:0] rand_item();
    logic [64:0] it;
    it = {1'($urandom_range(0, 1)), $urandom, $urandom};
    if ($urandom_range(0, 4) == 0) it[63:0] = 64'd0;
    return it;
  endfunction

  initial begin
    n_cmp = 0;
    n_bad = 0;
    started = 1'b0;
    i_reset_n = 1'b0;
    i_memop_sync_start = 1'b0;
    i_memop_sync_end = 1'b0;
    i_is_indexed = 1'b0;
    i_base_addr = '0;
    i_mask_idx_valid = 1'b0;
    i_mask_idx_item = '0;
    i_mask_idx_last_idx = 1'b0;
    i_req_ready = 1'b0;
    repeat (5) tick();
    i_reset_n = 1'b1;
    tick();

    // indexed: addresses 0x1010 and 0x0FF0 (wraps)
    i_req_ready = 1'b1;
    start_memop(1'b1, 64'h1000);
    push({1'b1, 64'h10}, 1'b0);
    push({1'b0, 64'hFFFF_FFFF_FFFF_FFF0}, 1'b1);
    drain();
    end_memop();

    // strided mask words, middle word zero
    start_memop(1'b0, 64'h2000);
    push({1'b0, $urandom, $urandom | 32'd1}, 1'b0);
    push({1'b0, 64'd0}, 1'b0);
    push({1'b0, $urandom, $urandom | 32'd1}, 1'b1);
    drain();
    end_memop();

    // simultaneous push and pop at occupancy 1
    i_req_ready = 1'b0;
    start_memop(1'b0, 64'h3000);
    push({1'b0, 64'hA}, 1'b0);
    i_req_ready = 1'b1;
    push({1'b0, 64'hB}, 1'b0);
    push({1'b0, 64'hC}, 1'b1);
    drain();
    end_memop();

    // backpressure: third push while full is dropped and flags an error
    i_req_ready = 1'b0;
    start_memop(1'b0, 64'h4000);
    push({1'b0, 64'h1}, 1'b0);
    push({1'b0, 64'h2}, 1'b1);
    push({1'b0, 64'h3}, 1'b0);
    repeat (3) tick();
    drain();
    end_memop();

    // reset with two entries queued
    i_req_ready = 1'b0;
    start_memop(1'b1, 64'h5000);
    push({1'b1, 64'h8}, 1'b0);
    push({1'b1, 64'h10}, 1'b1);
    i_reset_n = 1'b0;
    tick();
    i_reset_n = 1'b1;
    repeat (3) tick();

    // end strobe while an entry is still queued
    start_memop(1'b0, 64'h6000);
    push({1'b0, 64'hF0}, 1'b1);
    end_memop();
    drain();

    // randomized bursts, some long enough to saturate the element counter
    for (int b = 0; b < 24; b++) begin
      int n;
      int k;
      start_memop(1'($urandom_range(0, 1)), {$urandom, $urandom});
      n = $urandom_range(1, 12);
      k = 0;
      while (k < n) begin
        i_req_ready = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 2) != 0) begin
          i_mask_idx_valid = 1'b1;
          i_mask_idx_item = rand_item();
          i_mask_idx_last_idx = (k == n - 1);
          k++;
        end
        tick();
      end
      drain();
      end_memop();
    end

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
